buf_ram_writer: RTL
===================

Name: buf_ram_writer

Overview:
- Producer side of the 512x8 character buffer RAM that the display/readout path scans sequentially.
- Accepts a byte stream over a valid/ready handshake and writes it into the RAM at a circular write pointer.
- Uses the reader's address to apply back-pressure.
- Provides a bulk clear that fills the whole buffer with a fill character.

Parameters:
- ADDR_W, 9, RAM address width.
- DATA_W, 8, byte width.
- DEPTH, 512, number of RAM locations used; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- FILL, 8'h20, character written by clear (ASCII space).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  one-cycle request to fill the buffer with FILL.
- in_valid  input  1  in_data holds a byte.
- in_data  input  DATA_W  byte to store.
- in_ready  output  1  block accepts in_data this cycle.
- rd_ptr  input  ADDR_W  reader's current address (next location to be read).
- ram_wen  output  1  RAM write enable (to buf_ram wen).
- ram_addr  output  ADDR_W  RAM address (to buf_ram addr).
- ram_wdata  output  DATA_W  RAM write data (to buf_ram wdata).
- wr_ptr  output  ADDR_W  next location to be written.
- level  output  ADDR_W  occupied entries, (wr_ptr - rd_ptr) mod DEPTH.
- full  output  1  level == DEPTH-1.
- busy  output  1  clear in progress.
- clear_done  output  1  one-cycle pulse when the clear finishes.

Behaviour:
- Reset: state=RUN; wr_ptr=0, ram_wen=0, ram_addr=0, ram_wdata=0, busy=0, clear_done=0.
  - Reset wins over every other input, including mid-clear.
  - The write in flight on the reset cycle's output is dropped: ram_wen is 0 in the cycle after rst is sampled.
- full: combinational, (wr_ptr+1 wrapped at DEPTH) == rd_ptr. One slot is always kept empty, so wr_ptr == rd_ptr means empty.
- level: combinational. When wr_ptr < rd_ptr, level = wr_ptr + DEPTH - rd_ptr.
- in_ready: combinational, (state==RUN) && !full && !clear.
- State RUN, handshake (in_valid && in_ready):
  - Next cycle: ram_wen=1, ram_addr=old wr_ptr, ram_wdata=in_data. Latency from handshake to RAM write is 1 clock.
  - wr_ptr increments; DEPTH-1 wraps to 0. The wrap is explicit, so non-power-of-two DEPTH is supported.
  - With no handshake, ram_wen=0 next cycle. ram_addr and ram_wdata hold their last values.
  - Back-to-back handshakes give one write per cycle.
- State RUN with clear=1:
  - Clear has priority; no byte is accepted that cycle.
  - Go to CLEAR with an internal clr_addr=0; busy=1 from the next cycle.
- State CLEAR:
  - Each cycle: ram_wen=1, ram_addr=clr_addr, ram_wdata=FILL, then clr_addr increments.
  - Exactly DEPTH consecutive write cycles, covering addresses 0..DEPTH-1.
  - After the write to DEPTH-1: wr_ptr=0, state=RUN, busy=0, and clear_done=1 for one cycle, coincident with busy falling.
  - in_ready=0 throughout CLEAR.
  - clear asserted during CLEAR is ignored; it does not restart the clear.
- rd_ptr is owned by the reader and may change at any cycle; full, level and in_ready track it combinationally.
  - After clear_done the reader is expected to return to 0. Until it does, level reflects (0 - rd_ptr) mod DEPTH.
- No combinational path from in_data to any RAM port; all RAM-facing outputs are registered.

Test Plan:
1. Write two bytes.
   - Stimulus: reset, rd_ptr=0, send 0x48 then 0x49 on consecutive cycles.
   - Required: ram_wen high two cycles, addr 0 = 0x48 then addr 1 = 0x49, each one cycle after its handshake; wr_ptr=2, level=2, full=0.
2. Full and wrap.
   - Stimulus: rd_ptr=0, stream 511 bytes; then present a 512th byte (0x5A); then step rd_ptr to 1.
   - Required: after 511 bytes full=1, level=511, in_ready=0. The 512th byte is held until rd_ptr=1, then in_ready=1 and it is written to addr 511; wr_ptr wraps to 0.
3. Clear.
   - Stimulus: pulse clear for 1 cycle.
   - Required: busy=1 for exactly 512 cycles, ram_addr 0..511 in order, ram_wdata=0x20 throughout, clear_done pulses once with busy falling, wr_ptr=0.
   - Reading the RAM afterwards returns 0x20 everywhere.
4. Simultaneous clear and data.
   - Stimulus: clear=1 and in_valid=1 with in_data=0x41 in the same cycle.
   - Required: in_ready=0; 0x41 is never written; the clear proceeds normally.
5. Reset mid-clear.
   - Stimulus: assert rst while ram_addr=100 in CLEAR.
   - Required: next cycle ram_wen=0, busy=0, wr_ptr=0, clear_done never pulses; a subsequent byte is written to addr 0.
6. Non-power-of-two depth.
   - Stimulus: DEPTH=300, rd_ptr held at 150, write from wr_ptr=298.
   - Required: writes go to 298, 299, 0, 1, ...; a clear covers addresses 0..299 only (300 cycles); addresses 300..511 are untouched.

Source files
------------

// File: rtl/buf_ram_writer.sv
// Producer side of the character buffer RAM.
// Writes an incoming byte stream at a circular write pointer. The reader's
// address provides back-pressure. A bulk clear fills every location with FILL.
// All RAM-facing outputs are registered, one clock after the handshake.
module buf_ram_writer #(
    parameter int                 ADDR_W = 9,
    parameter int                 DATA_W = 8,
    parameter int                 DEPTH  = 512,
    parameter logic [DATA_W-1:0]  FILL   = 8'h20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_ptr,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] level,
    output logic              full,
    output logic              busy,
    output logic              clear_done
);

    // Last valid address. DEPTH taken modulo 2**ADDR_W for the level
    // arithmetic; the true level is always below DEPTH, so the wrap is exact.
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_M = ADDR_W'(DEPTH);

    typedef enum logic {S_RUN, S_CLEAR} state_t;

    // Explicit wrap so that non-power-of-two depths work.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        if (a == LAST)
            return '0;
        return a + ADDR_W'(1);
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                r_wen_p1;
    logic [ADDR_W-1:0]   r_addr_p1;
    logic [DATA_W-1:0]   r_wdata_p1;
    logic                r_done_p1;

    logic                w_full;
    logic                w_in_ready;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_level;
    logic                w_wen_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic [ADDR_W-1:0]   w_wr_nxt;
    logic [ADDR_W-1:0]   w_clr_nxt;
    logic                w_done_nxt;

    // One slot always stays empty so that equal pointers mean empty.
    assign w_full     = (wrap_inc(r_wr_ptr) == rd_ptr);
    assign w_in_ready = (r_state == S_RUN) && !w_full && !clear;
    assign w_accept   = in_valid && w_in_ready;

    // Occupancy modulo DEPTH; rd_ptr may move at any time.
    always_comb begin
        if (r_wr_ptr >= rd_ptr)
            w_level = r_wr_ptr - rd_ptr;
        else
            w_level = r_wr_ptr + DEPTH_M - rd_ptr;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic: clear only starts from RUN, so a clear during CLEAR is ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (clear) w_state_nxt = S_CLEAR;
            S_CLEAR: if (r_clr_addr == LAST) w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Output logic: next values of the registered RAM port and pointers.
    always_comb begin
        w_wen_nxt   = 1'b0;
        w_addr_nxt  = r_addr_p1;
        w_wdata_nxt = r_wdata_p1;
        w_wr_nxt    = r_wr_ptr;
        w_clr_nxt   = r_clr_addr;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_RUN: begin
                if (clear)
                    w_clr_nxt = '0;
                if (w_accept) begin
                    w_wen_nxt   = 1'b1;
                    w_addr_nxt  = r_wr_ptr;
                    w_wdata_nxt = in_data;
                    w_wr_nxt    = wrap_inc(r_wr_ptr);
                end
            end
            S_CLEAR: begin
                w_wen_nxt   = 1'b1;
                w_addr_nxt  = r_clr_addr;
                w_wdata_nxt = FILL;
                w_clr_nxt   = wrap_inc(r_clr_addr);
                if (r_clr_addr == LAST) begin
                    w_wr_nxt   = '0;
                    w_done_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // stage p1: registered RAM port, pointers and done pulse; reset drops any write in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen_p1   <= 1'b0;
            r_addr_p1  <= '0;
            r_wdata_p1 <= '0;
            r_wr_ptr   <= '0;
            r_clr_addr <= '0;
            r_done_p1  <= 1'b0;
        end else begin
            r_wen_p1   <= w_wen_nxt;
            r_addr_p1  <= w_addr_nxt;
            r_wdata_p1 <= w_wdata_nxt;
            r_wr_ptr   <= w_wr_nxt;
            r_clr_addr <= w_clr_nxt;
            r_done_p1  <= w_done_nxt;
        end
    end

    assign in_ready   = w_in_ready;
    assign full       = w_full;
    assign level      = w_level;
    assign wr_ptr     = r_wr_ptr;
    assign busy       = (r_state == S_CLEAR);
    assign clear_done = r_done_p1;
    assign ram_wen    = r_wen_p1;
    assign ram_addr   = r_addr_p1;
    assign ram_wdata  = r_wdata_p1;

endmodule
